// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, registered result plus NZCV/err flags out.
interface seq_alu_if #(parameter int WIDTH = 64);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       ALUOp;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             Zero;
   logic             Neg;
   logic             Carry;
   logic             Ovf;
   logic             err;

   modport master (
      output in_valid, a, b, ALUOp, out_ready,
      input  in_ready, out_valid, result, Zero, Neg, Carry, Ovf, err
   );

   modport slave (
      input  in_valid, a, b, ALUOp, out_ready,
      output in_ready, out_valid, result, Zero, Neg, Carry, Ovf, err
   );
endinterface

// File: rtl/seq_alu.sv
// Handshaked registered ALU: 1-cycle ops, WIDTH-cycle shift-add MUL; one op in flight.
// Result held in HOLD until out_ready; a new request is accepted in the same cycle it drains.
module seq_alu #(
   parameter int WIDTH  = 64,
   parameter bit MUL_EN = 1'b1
) (
   input logic      clk,
   input logic      reset,
   seq_alu_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] result_q, mcand, mplier, acc, acc_nxt;
   logic             zero_q, neg_q, carry_q, ovf_q, err_q;
   logic [SHW-1:0]   cnt;
   logic             rdy, accept, is_mul, start_mul, mul_done;

   logic [WIDTH-1:0] op_res;
   logic             op_carry, op_ovf, op_err;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   sh;

   assign sh      = bus.b[SHW-1:0];
   assign is_mul  = MUL_EN && (bus.ALUOp == 4'b1000);
   assign acc_nxt = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      op_res   = '0;
      op_carry = 1'b0;
      op_ovf   = 1'b0;
      op_err   = 1'b0;
      sum      = '0;
      case (bus.ALUOp)
         4'b0000: op_res = bus.a & bus.b;
         4'b0001: op_res = bus.a | bus.b;
         4'b1100: op_res = ~(bus.a | bus.b);
         4'b1010: op_res = bus.a ^ bus.b;
         4'b0010: begin
            sum      = {1'b0, bus.a} + {1'b0, bus.b};
            op_res   = sum[WIDTH-1:0];
            op_carry = sum[WIDTH];
            op_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'b0110: begin
            // carry out of a + ~b + 1 is the "no borrow" flag
            sum      = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
            op_res   = sum[WIDTH-1:0];
            op_carry = sum[WIDTH];
            op_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'b0011: op_res = bus.a << sh;
         4'b0100: op_res = bus.a >> sh;
         4'b0101: op_res = $signed(bus.a) >>> sh;
         4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         4'b1000: op_err = !MUL_EN;
         default: op_err = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      mul_done  = 1'b0;
      case (state)
         IDLE: rdy = 1'b1;
         MUL: begin
            if (cnt == SHW'(WIDTH - 1)) begin
               mul_done  = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            rdy = bus.out_ready;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      rdy       = rdy & reset;
      accept    = rdy & bus.in_valid;
      start_mul = accept & is_mul;
      if (accept) state_nxt = is_mul ? MUL : HOLD;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         if (start_mul) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
         end else if (accept) begin
            result_q <= op_res;
            zero_q   <= (op_res == '0);
            neg_q    <= op_res[WIDTH-1];
            carry_q  <= op_carry;
            ovf_q    <= op_ovf;
            err_q    <= op_err;
         end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_done) begin
               result_q <= acc_nxt;
               zero_q   <= (acc_nxt == '0);
               neg_q    <= acc_nxt[WIDTH-1];
               carry_q  <= 1'b0;
               ovf_q    <= 1'b0;
               err_q    <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (state == HOLD);
   assign bus.result    = result_q;
   assign bus.Zero      = zero_q;
   assign bus.Neg       = neg_q;
   assign bus.Carry     = carry_q;
   assign bus.Ovf       = ovf_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: scoreboard of arithmetic-model results checked every output cycle.
module tb_seq_alu;
   localparam int W = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu_if #(.WIDTH(W)) bus2 ();

   seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut       (.clk(clk), .reset(reset), .bus(bus));
   seq_alu #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (.clk(clk), .reset(reset), .bus(bus2));

   typedef struct packed {
      logic [63:0] res;
      logic n, z, c, v, e;
   } out_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      out_t        exp;
   } vec_t;

   typedef struct {
      out_t o;
      int   due;
   } pend_t;

   int    checks = 0;
   int    passes = 0;
   int    cyc = 0;
   pend_t q[$];
   pend_t p;
   bit    seen = 1'b0;
   vec_t  vt[16];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Reference behaviour from the opcode definitions, using wide exact arithmetic for the flags.
   function automatic out_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] op, input bit mul_en);
      out_t               o;
      logic signed [65:0] ex;
      logic signed [65:0] smax;
      logic signed [65:0] smin;
      logic [5:0]         sh;
      bit                 legal;
      o     = '0;
      ex    = '0;
      smax  = 66'sh0_7FFF_FFFF_FFFF_FFFF;
      smin  = -(66'sh0_8000_0000_0000_0000);
      sh    = b[5:0];
      legal = 1'b1;
      case (op)
         4'h0: o.res = a & b;
         4'h1: o.res = a | b;
         4'hC: o.res = ~(a | b);
         4'hA: o.res = a ^ b;
         4'h2: begin
            o.res = a + b;
            o.c   = (o.res < a);
            ex    = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
            o.v   = (ex > smax) || (ex < smin);
         end
         4'h6: begin
            o.res = a - b;
            o.c   = (a >= b);
            ex    = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
            o.v   = (ex > smax) || (ex < smin);
         end
         4'h3: o.res = a << sh;
         4'h4: o.res = a >> sh;
         4'h5: o.res = $signed(a) >>> sh;
         4'h7: o.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'h8: if (mul_en) o.res = a * b; else legal = 1'b0;
         default: legal = 1'b0;
      endcase
      if (legal) begin
         o.n = o.res[63];
         o.z = (o.res == 64'd0);
      end else begin
         o   = '0;
         o.z = 1'b1;
         o.e = 1'b1;
      end
      return o;
   endfunction

   function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] res, input logic [3:0] nzcv, input logic e);
      vec_t v;
      v.op  = op;
      v.a   = a;
      v.b   = b;
      v.exp = {res, nzcv, e};
      return v;
   endfunction

   function automatic out_t dut_out();
      return {bus.result, bus.Neg, bus.Zero, bus.Carry, bus.Ovf, bus.err};
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         q.delete();
         seen = 1'b0;
         chk("reset_outputs", {bus.out_valid, dut_out()}, '0);
      end else begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", bus.out_valid, 1'b0);
            end else begin
               if (!seen) begin
                  chk("latency", cyc, q[0].due);
                  seen = 1'b1;
               end
               if (bus.out_ready) begin
                  chk("result_drain", dut_out(), q[0].o);
                  void'(q.pop_front());
                  seen = 1'b0;
               end else begin
                  chk("result_hold", dut_out(), q[0].o);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            p.o   = model(bus.a, bus.b, bus.ALUOp, 1'b1);
            p.due = cyc + ((bus.ALUOp == 4'h8) ? W + 1 : 1);
            q.push_back(p);
         end
      end
   end

   task automatic send(input vec_t v, output int waited);
      bit got;
      chk("model_pin", model(v.a, v.b, v.op, 1'b1), v.exp);
      bus.a        = v.a;
      bus.b        = v.b;
      bus.ALUOp    = v.op;
      bus.in_valid = 1'b1;
      waited       = 0;
      got          = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         waited++;
         got = bus.in_ready;
      end
      if (!got) chk("accept_timeout", got, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int w;
      int n;
      vt[0]  = mk(4'h0, 64'd10, 64'd15, 64'd10, 4'b0000, 1'b0);
      vt[1]  = mk(4'h1, 64'd10, 64'd15, 64'd15, 4'b0000, 1'b0);
      vt[2]  = mk(4'hA, 64'd10, 64'd15, 64'd5, 4'b0000, 1'b0);
      vt[3]  = mk(4'hC, 64'd10, 64'd15, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 1'b0);
      vt[4]  = mk(4'h6, 64'd10, 64'd15, 64'hFFFF_FFFF_FFFF_FFFB, 4'b1000, 1'b0);
      vt[5]  = mk(4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
      vt[6]  = mk(4'h6, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0);
      vt[7]  = mk(4'h3, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000, 1'b0);
      vt[8]  = mk(4'h5, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 4'b1000, 1'b0);
      vt[9]  = mk(4'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 4'b0000, 1'b0);
      vt[10] = mk(4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1'b0);
      vt[11] = mk(4'h4, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4'b0000, 1'b0);
      vt[12] = mk(4'h8, 64'd3, 64'd5, 64'd15, 4'b0000, 1'b0);
      vt[13] = mk(4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
      vt[14] = mk(4'hF, 64'd7, 64'd9, 64'd0, 4'b0100, 1'b1);
      vt[15] = mk(4'h6, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.ALUOp     = '0;
      bus.out_ready = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.a         = '0;
      bus2.b         = '0;
      bus2.ALUOp     = '0;
      bus2.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;

      // single-cycle ops streamed back to back
      for (int i = 0; i < 12; i++) begin
         send(vt[i], w);
         chk("b2b_ready", w, 1);
      end

      // MUL busy window, then the all-ones multiplicand case
      send(vt[12], w);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
      end
      chk("mul_busy_cycles", n, 64);
      @(posedge clk);
      #1;
      send(vt[13], w);
      repeat (70) @(posedge clk);
      #1;

      // backpressure: a pending result stalls the next request, then both move in one cycle
      bus.out_ready = 1'b0;
      send(vt[0], w);
      chk("model_pin", model(vt[1].a, vt[1].b, vt[1].op, 1'b1), vt[1].exp);
      bus.a        = vt[1].a;
      bus.b        = vt[1].b;
      bus.ALUOp    = vt[1].op;
      bus.in_valid = 1'b1;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (!bus.in_ready) n++;
      end
      chk("stall_cycles", n, 5);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_and_accept", {bus.out_valid, bus.in_ready}, 2'b11);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      send(vt[14], w);
      send(vt[15], w);
      repeat (3) @(posedge clk);
      #1;

      // asynchronous reset in the middle of a MUL
      send(vt[12], w);
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("reset_async", {bus.out_valid, dut_out()}, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      n = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.out_valid) n++;
      end
      chk("no_result_after_reset", n, 0);
      @(posedge clk);
      #1;
      send(vt[14], w);
      repeat (3) @(posedge clk);
      #1;

      // MUL_EN=0 instance: MUL is illegal, ADD still works
      bus2.a        = 64'd3;
      bus2.b        = 64'd5;
      bus2.ALUOp    = 4'h8;
      bus2.in_valid = 1'b1;
      @(negedge clk);
      chk("nomul_ready", bus2.in_ready, 1'b1);
      @(posedge clk);
      #1 bus2.in_valid = 1'b0;
      @(negedge clk);
      chk("nomul_mul", {bus2.out_valid, bus2.result, bus2.Zero, bus2.err}, {1'b1, 64'd0, 1'b1, 1'b1});
      @(posedge clk);
      #1;
      bus2.ALUOp    = 4'h2;
      bus2.in_valid = 1'b1;
      @(posedge clk);
      #1 bus2.in_valid = 1'b0;
      @(negedge clk);
      chk("nomul_add", {bus2.out_valid, bus2.result, bus2.Zero, bus2.err}, {1'b1, 64'd8, 1'b0, 1'b0});

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
      $fatal(1);
   end
endmodule
